// File: rtl/cache_mshr_mem_arbiter.sv
// cache_mshr_mem_arbiter: round-robin arbiter sharing one memory read port among per-bank MSHR heads,
// merging buffered store words over the fetched block before filling the owning bank.
module cache_mshr_mem_arbiter #(
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int CW = $clog2(BLOCK_WORDS)
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [NUM_BANKS-1:0]                     mshr_valid,
  input  logic [NUM_BANKS*ADDR_W-1:0]              mshr_addr,
  input  logic [NUM_BANKS*BLOCK_WORDS-1:0]         mshr_write_status,
  input  logic [NUM_BANKS*BLOCK_WORDS*WORD_W-1:0]  mshr_write_block,
  output logic [NUM_BANKS-1:0]                     bank_free,
  output logic                                     mem_req,
  output logic [ADDR_W-1:0]                        mem_addr,
  input  logic                                     mem_ready,
  input  logic                                     mem_rvalid,
  input  logic [WORD_W-1:0]                        mem_rdata,
  output logic                                     fill_valid,
  output logic [BW-1:0]                            fill_bank,
  output logic [ADDR_W-1:0]                        fill_addr,
  output logic [BLOCK_WORDS*WORD_W-1:0]            fill_data,
  output logic                                     fill_dirty,
  input  logic                                     fill_ready,
  output logic                                     busy
);
  typedef enum logic [1:0] {IDLE, REQ, BEAT, FILL} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_rr_ptr, r_grant, w_pick, w_idx;
  logic [CW-1:0] r_beat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [BLOCK_WORDS-1:0] r_ws;
  logic [BLOCK_WORDS*WORD_W-1:0] r_wb, r_data;
  logic w_any, w_beat_last, w_fire_fill;
  assign w_beat_last = r_state == BEAT && mem_rvalid && r_beat_cnt == CW'(BLOCK_WORDS-1);
  assign w_fire_fill = r_state == FILL && fill_ready;
  // first valid bank at or above the round-robin pointer, wrapping
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_idx = BW'((int'(r_rr_ptr) + k) % NUM_BANKS);
      if (!w_any && mshr_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_any ? REQ : IDLE)
           : r_state == REQ  ? (mem_ready ? BEAT : REQ)
           : r_state == BEAT ? (w_beat_last ? FILL : BEAT)
           : (fill_ready ? IDLE : FILL);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_ws       <= '0;
      r_wb       <= '0;
      r_data     <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick;
        r_addr  <= mshr_addr[w_pick*ADDR_W +: ADDR_W];
        r_ws    <= mshr_write_status[w_pick*BLOCK_WORDS +: BLOCK_WORDS];
        r_wb    <= mshr_write_block[w_pick*BLOCK_WORDS*WORD_W +: BLOCK_WORDS*WORD_W];
      end
      if (r_state == REQ && mem_ready) r_beat_cnt <= '0;
      if (r_state == BEAT && mem_rvalid) begin
        r_data[r_beat_cnt*WORD_W +: WORD_W] <= mem_rdata;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_fire_fill) r_rr_ptr <= BW'((int'(r_grant) + 1) % NUM_BANKS);
    end
  always_comb begin
    mem_req    = r_state == REQ;
    mem_addr   = mem_req ? r_addr : '0;
    fill_valid = r_state == FILL;
    fill_bank  = fill_valid ? r_grant : '0;
    fill_addr  = fill_valid ? r_addr : '0;
    fill_dirty = fill_valid && |r_ws;
    busy       = r_state != IDLE;
    bank_free  = '0;
    if (w_fire_fill) bank_free[r_grant] = 1'b1;
    fill_data  = '0;
    for (int i = 0; i < BLOCK_WORDS; i++)
      fill_data[i*WORD_W +: WORD_W] = !fill_valid ? '0
                                    : r_ws[i] ? r_wb[i*WORD_W +: WORD_W] : r_data[i*WORD_W +: WORD_W];
  end
endmodule
